// File: rtl/bus_dmx_pkg.sv
// Shared types and helpers for the bus_dmx_1_8 transfer scheduler.
package bus_dmx_pkg;

   localparam int DMX_ADDR_W   = 3;
   localparam int DMX_NUM_DEST = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_e;

   function automatic logic [DMX_NUM_DEST-1:0] onehot8(input logic [DMX_ADDR_W-1:0] addr);
      logic [DMX_NUM_DEST-1:0] v;
      v       = '0;
      v[addr] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/bus_dmx_tmr.sv
// Loadable down-counter with zero flag; stops at zero until reloaded.
module bus_dmx_tmr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_dmx_sched.sv
// Transfer scheduler in front of bus_dmx_1_8: steer, strobe, wait for ack, turnaround gap.
// Define BUS_DMX_SCHED_TIMEOUT_EN to bound the ack wait by TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | ready for a word; masked words are dropped here
// DRIVE | demux steered, one-hot strobe held until the addressed ack
// GAP   | strobe low, bus held, turnaround countdown
module bus_dmx_sched
   import bus_dmx_pkg::*;
#(
   parameter int N           = 8,
   parameter int GAP_CYC     = 1,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DMX_ADDR_W-1:0]   in_addr,
   input  logic [N-1:0]            in_data,
   input  logic [DMX_NUM_DEST-1:0] cfg_mask,
   output logic [DMX_ADDR_W-1:0]   dmx_addr,
   output logic [N-1:0]            dmx_x,
   output logic [DMX_NUM_DEST-1:0] out_stb,
   input  logic [DMX_NUM_DEST-1:0] out_ack,
   output logic                    drop_pulse,
   output logic [7:0]              drop_cnt,
   output logic                    err_timeout
);

   localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

   state_e                    state_q;
   logic [DMX_ADDR_W-1:0]     dmx_addr_q;
   logic [N-1:0]              dmx_x_q;
   logic [DMX_NUM_DEST-1:0]   out_stb_q;
   logic                      drop_pulse_q;
   logic [7:0]                drop_cnt_q;
   logic                      ack_hit, tmo_hit, xfer_end, gap_zero;

   // dmx_addr_q doubles as the latched destination for the word in flight
   assign ack_hit  = (state_q == DRIVE) && out_ack[dmx_addr_q];
   assign xfer_end = ack_hit || tmo_hit;

   bus_dmx_tmr #(.W(4)) u_gap_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (xfer_end),
      .load_val_i (GAP_LOAD),
      .dec_i      (state_q == GAP),
      .zero_o     (gap_zero)
   );

`ifdef BUS_DMX_SCHED_TIMEOUT_EN
   logic tmo_zero, err_q;

   bus_dmx_tmr #(.W(8)) u_tmo_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     ((state_q == IDLE) && in_valid && !cfg_mask[in_addr]),
      .load_val_i (8'(TIMEOUT_CYC - 1)),
      .dec_i      (state_q == DRIVE),
      .zero_o     (tmo_zero)
   );

   // an ack landing on the last allowed cycle takes priority over the timeout
   assign tmo_hit = (state_q == DRIVE) && tmo_zero && !out_ack[dmx_addr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= tmo_hit;
   end

   assign err_timeout = err_q;
`else
   logic unused_tmo;
   assign unused_tmo  = |8'(TIMEOUT_CYC);
   assign tmo_hit     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         dmx_addr_q   <= '0;
         dmx_x_q      <= '0;
         out_stb_q    <= '0;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         drop_pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (cfg_mask[in_addr]) begin
                     drop_pulse_q <= 1'b1;
                     if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                  end else begin
                     dmx_addr_q <= in_addr;
                     dmx_x_q    <= in_data;
                     out_stb_q  <= onehot8(in_addr);
                     state_q    <= DRIVE;
                  end
               end
            end
            DRIVE: begin
               if (xfer_end) begin
                  out_stb_q <= '0;
                  state_q   <= (GAP_CYC > 0) ? GAP : IDLE;
               end
            end
            GAP: begin
               if (gap_zero) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign dmx_addr   = dmx_addr_q;
   assign dmx_x      = dmx_x_q;
   assign out_stb    = out_stb_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
